// File: rtl/btb_assoc_if.sv
// Fetch-side bundle for the set-associative BTB: update, invalidate, flush and lookup ports.
// The master drives requests and lookup PCs; the slave (the BTB) returns hits and targets.
interface btb_assoc_if #(
    parameter int unsigned PC_BITS  = 32,
    parameter int unsigned RD_PORTS = 2
);
    logic                               wr_en;
    logic [PC_BITS-1:0]                 orig_pc;
    logic [PC_BITS-1:0]                 target_pc;
    logic                               invalidate;
    logic [PC_BITS-1:0]                 pc_invalid;
    logic                               flush;
    logic [RD_PORTS-1:0][PC_BITS-1:0]   pc_in;
    logic [RD_PORTS-1:0]                hit;
    logic [RD_PORTS-1:0][PC_BITS-1:0]   next_pc;
    logic                               flush_busy;

    modport master (
        output wr_en, orig_pc, target_pc, invalidate, pc_invalid, flush, pc_in,
        input  hit, next_pc, flush_busy
    );

    modport slave (
        input  wr_en, orig_pc, target_pc, invalidate, pc_invalid, flush, pc_in,
        output hit, next_pc, flush_busy
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative multi-port branch target buffer with invalid-first/round-robin replacement
// and a one-set-per-cycle flush sequencer that suppresses lookups while it runs.
module btb_assoc #(
    parameter int unsigned PC_BITS  = 32,
    parameter int unsigned SETS     = 256,
    parameter int unsigned WAYS     = 4,
    parameter int unsigned RD_PORTS = 2
) (
    input logic        clk,
    input logic        rst,
    btb_assoc_if.slave bus
);
    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned WAY_BITS = $clog2(WAYS);
    localparam int unsigned TAG_BITS = PC_BITS - IDX_BITS - 1;

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e                state_q;
    logic [IDX_BITS-1:0]   cnt_q;
    logic [WAYS-1:0]       valid_q  [SETS];
    logic [WAY_BITS-1:0]   rr_q     [SETS];
    logic [TAG_BITS-1:0]   tag_q    [SETS][WAYS];
    logic [PC_BITS-1:0]    target_q [SETS][WAYS];

    function automatic logic [IDX_BITS-1:0] pc_idx(input logic [PC_BITS-1:0] pc);
        return pc[IDX_BITS:1];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [PC_BITS-1:0] pc);
        return pc[PC_BITS-1:IDX_BITS+1];
    endfunction

    // Lookups: combinational, forced to miss while the flush sequencer runs.
    logic [RD_PORTS-1:0]              hit_c;
    logic [RD_PORTS-1:0][PC_BITS-1:0] next_pc_c;

    always_comb begin
        hit_c     = '0;
        next_pc_c = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (state_q == StIdle && valid_q[pc_idx(bus.pc_in[p])][w] &&
                    tag_q[pc_idx(bus.pc_in[p])][w] == pc_tag(bus.pc_in[p])) begin
                    hit_c[p]     = 1'b1;
                    next_pc_c[p] = target_q[pc_idx(bus.pc_in[p])][w];
                end
            end
        end
    end

    assign bus.hit        = hit_c;
    assign bus.next_pc    = next_pc_c;
    assign bus.flush_busy = (state_q == StFlush);

    logic [IDX_BITS-1:0] w_idx, i_idx;
    logic [TAG_BITS-1:0] w_tag, i_tag;
    logic                wr_hit, free_found, inv_hit;
    logic [WAY_BITS-1:0] wr_hit_way, free_way, inv_way, wr_way;
    logic                wr_act, inv_act, rr_adv;

    // Victim choice looks only at pre-invalidate valid bits.
    always_comb begin
        w_idx      = pc_idx(bus.orig_pc);
        w_tag      = pc_tag(bus.orig_pc);
        i_idx      = pc_idx(bus.pc_invalid);
        i_tag      = pc_tag(bus.pc_invalid);
        wr_hit     = 1'b0;
        wr_hit_way = '0;
        free_found = 1'b0;
        free_way   = '0;
        inv_hit    = 1'b0;
        inv_way    = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[w_idx][w] && tag_q[w_idx][w] == w_tag) begin
                wr_hit     = 1'b1;
                wr_hit_way = WAY_BITS'(w);
            end
            if (!valid_q[w_idx][w]) begin
                free_found = 1'b1;
                free_way   = WAY_BITS'(w);
            end
            if (valid_q[i_idx][w] && tag_q[i_idx][w] == i_tag) begin
                inv_hit = 1'b1;
                inv_way = WAY_BITS'(w);
            end
        end
        inv_act = bus.invalidate && (state_q == StIdle) && inv_hit;
        // Same-PC collision: the invalidate wins and the write is dropped entirely.
        wr_act  = bus.wr_en && (state_q == StIdle) &&
                  !(bus.invalidate && bus.orig_pc == bus.pc_invalid);
        wr_way  = wr_hit ? wr_hit_way : (free_found ? free_way : rr_q[w_idx]);
        rr_adv  = wr_act && !wr_hit && !free_found;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (inv_act) valid_q[i_idx][inv_way] <= 1'b0;
                    if (wr_act)  valid_q[w_idx][wr_way]  <= 1'b1;
                    if (rr_adv)  rr_q[w_idx] <= rr_q[w_idx] + WAY_BITS'(1);
                    if (bus.flush) begin
                        state_q <= StFlush;
                        cnt_q   <= '0;
                    end
                end
                StFlush: begin
                    valid_q[cnt_q] <= '0;
                    rr_q[cnt_q]    <= '0;
                    cnt_q          <= cnt_q + IDX_BITS'(1);
                    if (cnt_q == IDX_BITS'(SETS - 1)) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag and target storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_act) begin
            tag_q[w_idx][wr_way]    <= w_tag;
            target_q[w_idx][wr_way] <= bus.target_pc;
        end
    end

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{bus.orig_pc[0], bus.pc_invalid[0], bus.pc_in};
endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed scenarios plus randomized traffic against a behavioural
// table model (SETS=4, WAYS=2, two lookup ports).
module tb_btb_assoc;
    localparam int unsigned PC_BITS  = 32;
    localparam int unsigned SETS     = 4;
    localparam int unsigned WAYS     = 2;
    localparam int unsigned RD_PORTS = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    btb_assoc_if #(.PC_BITS(PC_BITS), .RD_PORTS(RD_PORTS)) bus ();

    btb_assoc #(.PC_BITS(PC_BITS), .SETS(SETS), .WAYS(WAYS), .RD_PORTS(RD_PORTS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: a table of (valid, tag, target) per set/way, a replacement pointer per set,
    // and a flush countdown.
    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_rr    [SETS];
    int          m_busy_left;
    int          m_fidx;

    bit          s_we, s_inv, s_fl;
    logic [31:0] s_opc, s_tpc, s_ipc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 1) % SETS);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> ($clog2(SETS) + 1);
    endfunction

    function automatic int find_way(input logic [31:0] pc);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set_of(pc)][w] && m_tag[set_of(pc)][w] == tag_of(pc)) return w;
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_busy_left = 0;
        m_fidx      = 0;
    endtask

    task automatic model_step();
        int wh, ih, fr, s, v;
        if (m_busy_left > 0) begin
            for (int w = 0; w < WAYS; w++) m_valid[m_fidx][w] = 1'b0;
            m_rr[m_fidx] = 0;
            m_fidx++;
            m_busy_left--;
            return;
        end
        s  = set_of(s_opc);
        wh = find_way(s_opc);
        ih = find_way(s_ipc);
        fr = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) fr = w;
        if (s_inv && ih >= 0) m_valid[set_of(s_ipc)][ih] = 1'b0;
        if (s_we && !(s_inv && s_ipc == s_opc)) begin
            if (wh >= 0) begin
                m_tgt[s][wh] = s_tpc;
            end else begin
                v = (fr >= 0) ? fr : m_rr[s];
                if (fr < 0) m_rr[s] = (m_rr[s] + 1) % WAYS;
                m_valid[s][v] = 1'b1;
                m_tag[s][v]   = tag_of(s_opc);
                m_tgt[s][v]   = s_tpc;
            end
        end
        if (s_fl) begin
            m_busy_left = SETS;
            m_fidx      = 0;
        end
    endtask

    task automatic drive(input bit we, input logic [31:0] opc, input logic [31:0] tpc,
                         input bit inv, input logic [31:0] ipc, input bit fl,
                         input logic [31:0] p0, input logic [31:0] p1);
        logic [31:0] pcs [RD_PORTS];
        int          w;
        bus.wr_en = we;  bus.orig_pc = opc; bus.target_pc = tpc;
        bus.invalidate = inv; bus.pc_invalid = ipc; bus.flush = fl;
        bus.pc_in[0] = p0; bus.pc_in[1] = p1;
        s_we = we; s_opc = opc; s_tpc = tpc; s_inv = inv; s_ipc = ipc; s_fl = fl;
        pcs[0] = p0; pcs[1] = p1;
        #1;
        for (int p = 0; p < RD_PORTS; p++) begin
            w = (m_busy_left > 0) ? -1 : find_way(pcs[p]);
            check($sformatf("hit%0d", p), 64'(bus.hit[p]), 64'(w >= 0));
            if (w >= 0) check($sformatf("next_pc%0d", p), 64'(bus.next_pc[p]),
                              64'(m_tgt[set_of(pcs[p])][w]));
        end
        check("flush_busy", 64'(bus.flush_busy), 64'(m_busy_left > 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write(input logic [31:0] opc, input logic [31:0] tpc);
        drive(1'b1, opc, tpc, 1'b0, 32'h0, 1'b0, opc, opc);
        tick();
    endtask

    task automatic look(input logic [31:0] p0, input logic [31:0] p1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, p0, p1);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h100 + ($urandom_range(0, 7) << 3) + ($urandom_range(0, SETS - 1) << 1);
    endfunction

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.invalidate = 1'b0; bus.flush = 1'b0;
        bus.orig_pc = '0; bus.target_pc = '0; bus.pc_invalid = '0; bus.pc_in = '0;
        model_reset();
        #1;
        check("rst_busy", 64'(bus.flush_busy), 64'd0);
        check("rst_hit", 64'(bus.hit), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill and hit
        write(32'h100, 32'h200);
        write(32'h108, 32'h300);
        look(32'h100, 32'h108);
        check("fill_hit", 64'(bus.hit), 64'b11);
        check("fill_np0", 64'(bus.next_pc[0]), 64'h200);
        check("fill_np1", 64'(bus.next_pc[1]), 64'h300);
        tick();
        look(32'h104, 32'h100);
        check("idx2_miss", 64'(bus.hit), 64'b10);
        tick();

        // Write hit updates in place
        write(32'h100, 32'h400);
        look(32'h100, 32'h108);
        check("upd_np0", 64'(bus.next_pc[0]), 64'h400);
        check("upd_np1", 64'(bus.next_pc[1]), 64'h300);
        tick();

        // Round-robin eviction: way 0 then way 1
        write(32'h110, 32'h500);
        write(32'h100, 32'h600);
        look(32'h108, 32'h110);
        check("rr_hit", 64'(bus.hit), 64'b10);
        check("rr_np1", 64'(bus.next_pc[1]), 64'h500);
        tick();
        look(32'h100, 32'h108);
        check("rr_np0", 64'(bus.next_pc[0]), 64'h600);
        tick();

        // Invalidate, refill of the freed way, same-PC collision
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h110, 1'b0, 32'h110, 32'h100);
        tick();
        look(32'h110, 32'h100);
        check("inv_hit", 64'(bus.hit), 64'b10);
        tick();
        write(32'h118, 32'h800);
        look(32'h118, 32'h100);
        check("refill_hit", 64'(bus.hit), 64'b11);
        tick();
        drive(1'b1, 32'h120, 32'h700, 1'b1, 32'h120, 1'b0, 32'h120, 32'h120);
        tick();
        look(32'h120, 32'h118);
        check("coll_miss", 64'(bus.hit), 64'b10);
        tick();
        write(32'h130, 32'h990);
        look(32'h118, 32'h100);
        check("coll_rr", 64'(bus.hit), 64'b10);
        tick();

        // Flush with a full set and a busy-time write
        write(32'h106, 32'h900);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100, 32'h130);
        check("pre_flush_hit", 64'(bus.hit), 64'b11);
        tick();
        for (int i = 0; i < SETS; i++) begin
            drive(1'b1, 32'h102, 32'hA00, 1'b0, 32'h0, 1'b0, 32'h100, 32'h106);
            check("flush_busy_hi", 64'(bus.flush_busy), 64'd1);
            check("flush_hit0", 64'(bus.hit), 64'd0);
            tick();
        end
        look(32'h100, 32'h102);
        check("flush_done", 64'(bus.flush_busy), 64'd0);
        check("flush_miss", 64'(bus.hit), 64'd0);
        tick();
        look(32'h106, 32'h130);
        check("flush_miss2", 64'(bus.hit), 64'd0);
        tick();

        // Reset mid-flush
        write(32'h106, 32'h900);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h106, 32'h106);
        tick();
        look(32'h106, 32'h100);
        tick();
        look(32'h106, 32'h100);
        tick();
        look(32'h106, 32'h100);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid_busy", 64'(bus.flush_busy), 64'd0);
        check("rst_mid_hit", 64'(bus.hit), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        write(32'h10A, 32'hB00);
        look(32'h10A, 32'h106);
        check("post_rst_hit", 64'(bus.hit), 64'b01);
        check("post_rst_np", 64'(bus.next_pc[0]), 64'hB00);
        tick();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic [31:0] wpc, ipc;
            bit          we, inv;
            wpc = rand_pc();
            we  = ($urandom_range(0, 2) != 0);
            inv = ($urandom_range(0, 4) == 0);
            ipc = ($urandom_range(0, 3) == 0) ? wpc : rand_pc();
            drive(we, wpc, $urandom, inv, ipc, ($urandom_range(0, 59) == 0),
                  rand_pc(), rand_pc());
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
